vfu_wb_sequencer: RTL
=====================

VFU_WB_SEQUENCER -- requirements
Module: vfu_wb_sequencer

Interface
REQ-001 SHALL have parameter DataWidth, default 64, VRF beat data width in bits.
REQ-002 SHALL have parameter AddrWidth, default 10, VRF element address width.
REQ-003 SHALL have parameter IdWidth, default 3, instruction ID width.
REQ-004 SHALL have parameter CntWidth, default 8, beat-count width.
REQ-005 SHALL have parameter FifoDepth, default 2, result buffer entries (>=2).
REQ-006 SHALL have port clk_i  in  1  clock; all state updates on rising edge.
REQ-007 SHALL have port rst_i  in  1  reset; one clock, synchronous, active-high.
REQ-008 SHALL have ports req_valid_i in 1 / req_ready_o out 1: writeback request handshake.
REQ-009 SHALL have ports req_addr_i in AddrWidth / req_cnt_i in CntWidth / req_id_i in IdWidth: start VRF address, beat count, instruction ID.
REQ-010 SHALL have ports res_valid_i in 1 / res_ready_o out 1: VFU result handshake.
REQ-011 SHALL have ports res_data_i in DataWidth / res_strb_i in DataWidth/8: result beat and byte strobe.
REQ-012 SHALL have ports wb_valid_o out 1 / wb_gnt_i in 1: VRF write request, same-cycle grant.
REQ-013 SHALL have ports wb_addr_o out AddrWidth / wb_data_o out DataWidth / wb_strb_o out DataWidth/8 / wb_id_o out IdWidth: write payload.
REQ-014 SHALL have ports done_o out 1 / done_id_o out IdWidth: one-cycle completion pulse and its ID.

Function
REQ-015 SHALL implement states IDLE and WORKING.
REQ-016 In IDLE, req_ready_o SHALL be 1. req_valid_i with req_cnt_i>0 SHALL latch addr/cnt/id, load in_cnt=out_cnt=req_cnt_i, and enter WORKING.
REQ-017 A req_cnt_i==0 request SHALL be accepted with no beats, no state change, and a done_o pulse with done_id_o=req_id_i on the next cycle.
REQ-018 In WORKING, req_ready_o SHALL be 0 except in the cycle of the final grant (REQ-023).
REQ-019 res_ready_o SHALL be 1 iff state==WORKING, in_cnt>0, and FIFO occupancy<FifoDepth. It SHALL NOT depend combinationally on wb_gnt_i.
REQ-020 Each res_valid_i&&res_ready_o SHALL push {data,strb} into the FIFO and decrement in_cnt.
REQ-021 The FIFO SHALL be registered, not fall-through: a beat pushed in cycle N appears on wb_valid_o no earlier than cycle N+1.
REQ-022 wb_valid_o SHALL be 1 iff WORKING and FIFO non-empty. The FIFO head SHALL drive wb_data_o/wb_strb_o, with wb_addr_o = current address and wb_id_o = latched ID. The payload SHALL remain stable until granted, and wb_valid_o SHALL NOT drop without a grant.
REQ-023 On wb_valid_o&&wb_gnt_i: pop FIFO, increment address modulo 2^AddrWidth, decrement out_cnt. If out_cnt==1, SHALL assert done_o with the latched ID in the same cycle, set req_ready_o=1, and either accept a new request (back-to-back, stay WORKING with newly loaded state) or return to IDLE.
REQ-024 wb_gnt_i while wb_valid_o==0 SHALL be ignored.
REQ-025 Simultaneous push and pop SHALL keep occupancy unchanged. Push and pop SHALL never occur on an empty-pop or full-push.
REQ-026 Counters SHALL be CntWidth unsigned and SHALL never underflow. Beats beyond req_cnt_i SHALL NOT be accepted.

Reset
REQ-027 While rst_i=1: state=IDLE, FIFO empty, counters 0, req_ready_o=0, res_ready_o=0, wb_valid_o=0, done_o=0, wb_addr_o/wb_data_o/wb_strb_o/wb_id_o/done_id_o=0.
REQ-028 Reset mid-operation SHALL discard buffered beats and in-flight request without any done_o. req_ready_o=1 the first cycle after rst_i falls.

Verification
REQ-029 Request addr=0x010, cnt=3, id=2, results every cycle, wb_gnt_i tied 1 -> writes at 0x010,0x011,0x012 in order with matching data. Single done_o with done_id_o=2 on the third grant.
REQ-030 cnt=4, wb_gnt_i held 0 for 5 cycles -> res_ready_o drops after 2 beats buffered. wb_valid_o and payload remain stable. After grant, all 4 beats are written with none lost or duplicated.
REQ-031 Back-to-back: second request (addr=0x3FF, cnt=2, id=5) valid during first request's final grant -> accepted that cycle, no IDLE bubble. Addresses 0x3FF then 0x000 (wrap).
REQ-032 cnt=0, id=7 -> no wb_valid_o, done_o pulse with done_id_o=7 the next cycle.
REQ-033 rst_i asserted after 1 of 3 beats written -> all outputs 0 during reset, no done_o, FIFO empty. A fresh request afterwards completes normally.
REQ-034 Extra res_valid_i beyond cnt, and wb_gnt_i pulses with wb_valid_o=0 -> neither is accepted, with no state change.

Source files
------------

// File: rtl/vfu_wb_sequencer.sv
// Generic synchronous FIFO. A write becomes visible at the head one cycle later.
// Pushes while full and pops while empty are dropped. Reset empties the buffer.
module vfu_wb_fifo #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// Writes a counted burst of VFU result beats to consecutive VRF addresses.
// A result reaches wb_valid_o one cycle after it is accepted. res_ready_o drops when
// the buffer is full or all beats are in. The write request holds until wb_gnt_i.
module vfu_wb_sequencer #(
    parameter int DataWidth = 64,
    parameter int AddrWidth = 10,
    parameter int IdWidth   = 3,
    parameter int CntWidth  = 8,
    parameter int FifoDepth = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [CntWidth-1:0]    req_cnt_i,
    input  logic [IdWidth-1:0]     req_id_i,
    input  logic                   res_valid_i,
    output logic                   res_ready_o,
    input  logic [DataWidth-1:0]   res_data_i,
    input  logic [DataWidth/8-1:0] res_strb_i,
    output logic                   wb_valid_o,
    input  logic                   wb_gnt_i,
    output logic [AddrWidth-1:0]   wb_addr_o,
    output logic [DataWidth-1:0]   wb_data_o,
    output logic [DataWidth/8-1:0] wb_strb_o,
    output logic [IdWidth-1:0]     wb_id_o,
    output logic                   done_o,
    output logic [IdWidth-1:0]     done_id_o
);
    localparam int StrbWidth = DataWidth / 8;
    localparam int BeatWidth = DataWidth + StrbWidth;

    typedef enum logic {
        IDLE,
        WORKING
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [CntWidth-1:0]  in_cnt_q, in_cnt_d;
    logic [CntWidth-1:0]  out_cnt_q, out_cnt_d;
    logic                 zero_done_q, zero_done_d;
    logic [IdWidth-1:0]   zero_id_q, zero_id_d;

    logic                 fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [BeatWidth-1:0] fifo_head;
    logic                 wb_fire, last_beat, req_accept;

    vfu_wb_fifo #(
        .Width (BeatWidth),
        .Depth (FifoDepth)
    ) u_res_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .wdata_i ({res_strb_i, res_data_i}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            id_q        <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            zero_done_q <= 1'b0;
            zero_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            zero_done_q <= zero_done_d;
            zero_id_q   <= zero_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        id_d        = id_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        zero_done_d = 1'b0;
        zero_id_d   = zero_id_q;

        // Every output is forced low while reset is held, even before the state clears.
        res_ready_o = !rst_i && (state_q == WORKING) && (in_cnt_q != '0) && !fifo_full;
        wb_valid_o  = !rst_i && (state_q == WORKING) && !fifo_empty;
        wb_fire     = wb_valid_o && wb_gnt_i;
        last_beat   = wb_fire && (out_cnt_q == CntWidth'(1));
        req_ready_o = !rst_i && ((state_q == IDLE) || last_beat);
        req_accept  = req_valid_i && req_ready_o;
        fifo_push   = res_valid_i && res_ready_o;
        fifo_pop    = wb_fire;

        done_o    = last_beat || (zero_done_q && !rst_i);
        done_id_o = '0;
        if (last_beat) begin
            done_id_o = id_q;
        end else if (zero_done_q && !rst_i) begin
            done_id_o = zero_id_q;
        end

        wb_addr_o = wb_valid_o ? addr_q : '0;
        wb_id_o   = wb_valid_o ? id_q : '0;
        wb_data_o = wb_valid_o ? fifo_head[DataWidth-1:0] : '0;
        wb_strb_o = wb_valid_o ? fifo_head[BeatWidth-1:DataWidth] : '0;

        if (fifo_push) begin
            in_cnt_d = in_cnt_q - CntWidth'(1);
        end
        if (wb_fire) begin
            addr_d    = addr_q + AddrWidth'(1);
            out_cnt_d = out_cnt_q - CntWidth'(1);
        end
        if (last_beat) begin
            state_d = IDLE;
        end
        // A new request may land in the same cycle as the final grant of the previous one.
        if (req_accept) begin
            if (req_cnt_i == '0) begin
                zero_done_d = 1'b1;
                zero_id_d   = req_id_i;
            end else begin
                state_d   = WORKING;
                addr_d    = req_addr_i;
                id_d      = req_id_i;
                in_cnt_d  = req_cnt_i;
                out_cnt_d = req_cnt_i;
            end
        end
    end
endmodule
